// File: rtl/byte_serializer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// byte_serializer_ctrl_pkg
//   Shared definitions for the byte serializer controller: default word/byte
//   widths, derivation helpers for lane count and lane-index width, and the
//   controller state encoding.
// -----------------------------------------------------------------------------
package byte_serializer_ctrl_pkg;

  localparam int DATA_W_DEF = 18;
  localparam int BYTE_W_DEF = 8;

  // Lanes needed to carry a dw-bit word in bw-bit bytes (ceiling division).
  function automatic int calc_nbytes(input int dw, input int bw);
    return (dw + bw - 1) / bw;
  endfunction

  // Lane-index width; kept at least 1 bit so a single-lane build still has a
  // legal counter.
  function automatic int calc_cnt_w(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage : byte_serializer_ctrl_pkg

// File: rtl/byte_serializer_ctrl_lane_select.sv
// -----------------------------------------------------------------------------
// byte_lane_select
//   Combinational lane picker: returns byte lane i_idx of i_word, LSB lane
//   first. Bits above DATA_W in the top lane read as zero.
// Ports
//   i_word  in   DATA_W  word being serialised
//   i_idx   in   CNT_W   lane index
//   o_byte  out  BYTE_W  selected lane
// -----------------------------------------------------------------------------
module byte_lane_select #(
  parameter int DATA_W = 18,
  parameter int BYTE_W = 8,
  parameter int NBYTES = 3,
  parameter int CNT_W  = 2
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [CNT_W-1:0]  i_idx,
  output logic [BYTE_W-1:0] o_byte
);

  // Word widened to a whole number of lanes so every part-select stays in range.
  logic [NBYTES*BYTE_W-1:0] w_padded;

  // NOTE: a combinational block assigns every output a default first; a path
  // that leaves a signal unassigned would infer a latch.
  always_comb begin
    w_padded               = '0;
    w_padded[DATA_W-1:0]   = i_word;
  end

  assign o_byte = w_padded[int'(i_idx)*BYTE_W +: BYTE_W];

endmodule : byte_lane_select

// File: rtl/byte_serializer_ctrl.sv
// -----------------------------------------------------------------------------
// byte_serializer_ctrl
//   Accepts one DATA_W-bit word from a valid/ready producer and emits it as
//   BYTE_W-bit bytes, LSB byte first, to a valid/ready/last consumer. The
//   number of bytes per word is in_nbytes+1, clamped to NBYTES. A word can be
//   reloaded on the last-byte handshake, so consecutive words stream with no
//   idle cycle.
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous active-high reset
//   in_valid   in   1       producer has a word
//   in_ready   out  1       word accepted this cycle (combinational on out_ready)
//   in_data    in   DATA_W  word to serialise
//   in_nbytes  in   CNT_W   bytes to emit minus 1, sampled with the word
//   out_valid  out  1       out_data holds a valid byte
//   out_ready  in   1       consumer takes the byte
//   out_data   out  BYTE_W  current byte (zero when out_valid is low)
//   out_last   out  1       current byte is the final byte of the word
//   shift_cnt  out  CNT_W   current lane index
//   busy       out  1       controller is in SEND
// -----------------------------------------------------------------------------
module byte_serializer_ctrl
  import byte_serializer_ctrl_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int BYTE_W = BYTE_W_DEF,
  localparam int NBYTES = calc_nbytes(DATA_W, BYTE_W),
  localparam int CNT_W  = calc_cnt_w(NBYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_nbytes,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  output logic [CNT_W-1:0]  shift_cnt,
  output logic              busy
);

  localparam logic [CNT_W-1:0] MAX_IDX = CNT_W'(NBYTES - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [DATA_W-1:0]  r_word;
  logic [CNT_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_nb;

  logic [CNT_W-1:0]   w_nb_clamped;
  logic [BYTE_W-1:0]  w_lane;
  logic               w_load;
  logic               w_inc;
  logic               w_clr;
  logic               w_valid;
  logic               w_last;
  logic               w_in_ready;

  // The CNT_W-bit field can encode one more than the last legal lane index.
  assign w_nb_clamped = (in_nbytes > MAX_IDX) ? MAX_IDX : in_nbytes;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_inc       = 1'b0;
    w_clr       = 1'b0;
    w_valid     = 1'b0;
    w_last      = 1'b0;
    w_in_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        w_valid = 1'b1;
        w_last  = (r_idx == r_nb);
        if (out_ready) begin
          if (!w_last) begin
            w_inc = 1'b1;
          end else begin
            // Last byte leaving: the slot frees up this same cycle, so a
            // waiting word is taken immediately and streaming has no bubble.
            w_in_ready = 1'b1;
            if (in_valid) begin
              w_load = 1'b1;
            end else begin
              w_clr       = 1'b1;
              w_state_nxt = IDLE;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_idx   <= '0;
      r_nb    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_word <= in_data;
        r_nb   <= w_nb_clamped;
        r_idx  <= '0;
      end else if (w_inc) begin
        r_idx  <= r_idx + CNT_W'(1);
      end else if (w_clr) begin
        r_idx  <= '0;
      end
    end
  end

  byte_lane_select #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W),
    .NBYTES (NBYTES),
    .CNT_W  (CNT_W)
  ) u_lane_select (
    .i_word (r_word),
    .i_idx  (r_idx),
    .o_byte (w_lane)
  );

  // Held low while rst is asserted so no word is offered a handshake that the
  // reset would immediately discard.
  assign in_ready  = w_in_ready & ~rst;
  assign out_valid = w_valid;
  assign out_last  = w_last;
  assign out_data  = w_valid ? w_lane : '0;
  assign shift_cnt = r_idx;
  assign busy      = (r_state == SEND);

endmodule : byte_serializer_ctrl
